// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit for the execute stage.
// Shift-add multiply (LSB first) and restoring divide (MSB first), one bit per cycle.
module mdu_iter #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hold,
  input  logic            flush,
  output logic            e_wait,
  output logic            out_valid,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_W   = CNT_W'(31);
  localparam logic [CNT_W-1:0] LAST_D   = CNT_W'(XLEN - 1);

  function automatic logic [63:0] sext32(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return 64'd0 - v;
  endfunction

  state_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           mul_q, mul_d, w_q, w_d, hi_q, hi_d, remsel_q, remsel_d;
  logic           neg_q, neg_d, rneg_q, rneg_d;
  logic [127:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [63:0]    mplier_q, mplier_d, prem_q, prem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [63:0]    result_q, result_d;

  logic           legal_s, mul_s, w_s, sa_s, sb_s, hi_s, remsel_s;
  logic [63:0]    a_ext_s, b_ext_s, a_abs_s, b_abs_s;
  logic           a_neg_s, b_neg_s, b_zero_s, ovf_s, last_s;
  logic [127:0]   add_s, prod_s;
  logic [64:0]    rem_sh_s, diff_s;
  logic           qbit_s;
  logic [63:0]    prem_nx_s, quo_nx_s, qv_s, rv_s, fin_s, sel_s;

  // Opcode decode into datapath controls.
  always_comb begin
    legal_s = 1'b1; mul_s = 1'b0; w_s = 1'b0; sa_s = 1'b0;
    sb_s = 1'b0; hi_s = 1'b0; remsel_s = 1'b0;
    case (op)
      4'd0:  mul_s = 1'b1;
      4'd1:  begin mul_s = 1'b1; hi_s = 1'b1; sa_s = 1'b1; sb_s = 1'b1; end
      4'd2:  begin mul_s = 1'b1; hi_s = 1'b1; sa_s = 1'b1; end
      4'd3:  begin mul_s = 1'b1; hi_s = 1'b1; end
      4'd4:  begin sa_s = 1'b1; sb_s = 1'b1; end
      4'd5:  legal_s = 1'b1;
      4'd6:  begin sa_s = 1'b1; sb_s = 1'b1; remsel_s = 1'b1; end
      4'd7:  remsel_s = 1'b1;
      4'd8:  begin mul_s = 1'b1; w_s = 1'b1; end
      4'd9:  begin w_s = 1'b1; sa_s = 1'b1; sb_s = 1'b1; end
      4'd10: w_s = 1'b1;
      4'd11: begin w_s = 1'b1; sa_s = 1'b1; sb_s = 1'b1; remsel_s = 1'b1; end
      4'd12: begin w_s = 1'b1; remsel_s = 1'b1; end
      default: legal_s = 1'b0;
    endcase
  end

  // W ops see only the low word; signed variants sign-extend it.
  assign a_ext_s  = w_s ? (sa_s ? sext32(a) : {32'd0, a[31:0]}) : a;
  assign b_ext_s  = w_s ? (sb_s ? sext32(b) : {32'd0, b[31:0]}) : b;
  assign a_neg_s  = sa_s & a_ext_s[63];
  assign b_neg_s  = sb_s & b_ext_s[63];
  assign a_abs_s  = a_neg_s ? neg64(a_ext_s) : a_ext_s;
  assign b_abs_s  = b_neg_s ? neg64(b_ext_s) : b_ext_s;
  assign b_zero_s = (b_ext_s == 64'd0);
  assign ovf_s    = sa_s & sb_s & ~mul_s &
                    (w_s ? ((a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF))
                         : ((a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF)));
  assign last_s   = (cnt_q == (w_q ? LAST_W : LAST_D));

  // One iteration of both datapaths plus final sign fix-up and selection.
  always_comb begin
    add_s     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    prod_s    = neg_q ? (128'd0 - add_s) : add_s;
    rem_sh_s  = {prem_q, quo_q[63]};
    diff_s    = rem_sh_s - {1'b0, dvs_q};
    qbit_s    = ~diff_s[64];
    prem_nx_s = qbit_s ? diff_s[63:0] : rem_sh_s[63:0];
    quo_nx_s  = {quo_q[62:0], qbit_s};
    qv_s      = neg_q ? neg64(quo_nx_s) : quo_nx_s;
    rv_s      = rneg_q ? neg64(prem_nx_s) : prem_nx_s;
    if (mul_q) begin
      sel_s = hi_q ? prod_s[127:64] : prod_s[63:0];
    end else begin
      sel_s = remsel_q ? rv_s : qv_s;
    end
    fin_s = w_q ? sext32(sel_s) : sel_s;
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q; cnt_d = cnt_q; mul_d = mul_q; w_d = w_q; hi_d = hi_q;
    remsel_d = remsel_q; neg_d = neg_q; rneg_d = rneg_q; acc_d = acc_q;
    mcand_d = mcand_q; mplier_d = mplier_q; prem_d = prem_q; quo_d = quo_q;
    dvs_d = dvs_q; result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          mul_d    = mul_s;
          w_d      = w_s;
          hi_d     = hi_s;
          remsel_d = remsel_s;
          neg_d    = a_neg_s ^ b_neg_s;
          rneg_d   = a_neg_s;
          cnt_d    = CNT_ZERO;
          acc_d    = 128'd0;
          mcand_d  = {64'd0, a_abs_s};
          mplier_d = b_abs_s;
          prem_d   = 64'd0;
          quo_d    = w_s ? {a_abs_s[31:0], 32'd0} : a_abs_s;
          dvs_d    = b_abs_s;
          if (!legal_s) begin
            result_d = 64'd0;
            state_d  = DONE;
          end else if (!mul_s && b_zero_s) begin
            result_d = remsel_s ? (w_s ? sext32(a) : a) : 64'hFFFF_FFFF_FFFF_FFFF;
            state_d  = DONE;
          end else if (ovf_s) begin
            result_d = remsel_s ? 64'd0 : (w_s ? sext32(a) : a);
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          cnt_d    = cnt_q + CNT_ONE;
          acc_d    = add_s;
          mcand_d  = {mcand_q[126:0], 1'b0};
          mplier_d = {1'b0, mplier_q[63:1]};
          prem_d   = prem_nx_s;
          quo_d    = quo_nx_s;
          if (last_s) begin
            result_d = fin_s;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      DONE: begin
        if (flush) begin
          state_d = IDLE;
        end else if (hold) begin
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE; cnt_q <= CNT_ZERO; mul_q <= 1'b0; w_q <= 1'b0; hi_q <= 1'b0;
      remsel_q <= 1'b0; neg_q <= 1'b0; rneg_q <= 1'b0; acc_q <= 128'd0;
      mcand_q <= 128'd0; mplier_q <= 64'd0; prem_q <= 64'd0; quo_q <= 64'd0;
      dvs_q <= 64'd0; result_q <= 64'd0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; mul_q <= mul_d; w_q <= w_d; hi_q <= hi_d;
      remsel_q <= remsel_d; neg_q <= neg_d; rneg_q <= rneg_d; acc_q <= acc_d;
      mcand_q <= mcand_d; mplier_q <= mplier_d; prem_q <= prem_d; quo_q <= quo_d;
      dvs_q <= dvs_d; result_q <= result_d;
    end
  end

  // Acceptance-cycle stall is combinational so the hazard unit sees it immediately.
  always_comb begin
    case (state_q)
      IDLE:    e_wait = resetn & in_valid & ~flush;
      CALC:    e_wait = resetn;
      DONE:    e_wait = 1'b0;
      default: e_wait = 1'b0;
    endcase
  end

  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed plan vectors plus randomized ops
// checked against an arithmetic reference model.
module tb_mdu_iter;
  logic        clk = 1'b0;
  logic        resetn, in_valid, hold, flush;
  logic [3:0]  op;
  logic [63:0] a, b;
  logic        e_wait, out_valid;
  logic [63:0] result;

  int vectors = 0;
  int miscompares = 0;
  int checks = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  mdu_iter #(.XLEN(64), .CNT_W(7)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .op(op), .a(a), .b(b),
    .hold(hold), .flush(flush), .e_wait(e_wait), .out_valid(out_valid), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
    logic signed [127:0] sx, sy, zx, zy, p;
    logic signed [63:0]  x64, y64, r64;
    logic signed [31:0]  x32, y32, r32;
    logic [31:0]         ux32, uy32, ur32;
    logic [63:0]         r;
    sx = {{64{x[63]}}, x}; sy = {{64{y[63]}}, y};
    zx = {64'd0, x};       zy = {64'd0, y};
    x64 = x; y64 = y; x32 = x[31:0]; y32 = y[31:0]; ux32 = x[31:0]; uy32 = y[31:0];
    r = 64'd0;
    case (o)
      4'd0: begin p = zx * zy; r = p[63:0]; end
      4'd1: begin p = sx * sy; r = p[127:64]; end
      4'd2: begin p = sx * zy; r = p[127:64]; end
      4'd3: begin p = zx * zy; r = p[127:64]; end
      4'd4: if (y == 64'd0) r = ONES; else if (x == MINV && y == ONES) r = x;
            else begin r64 = x64 / y64; r = r64; end
      4'd5: if (y == 64'd0) r = ONES; else r = x / y;
      4'd6: if (y == 64'd0) r = x; else if (x == MINV && y == ONES) r = 64'd0;
            else begin r64 = x64 % y64; r = r64; end
      4'd7: if (y == 64'd0) r = x; else r = x % y;
      4'd8: begin p = zx * zy; r = sx32(p[31:0]); end
      4'd9: if (uy32 == 32'd0) r = ONES; else if (ux32 == 32'h8000_0000 && uy32 == 32'hFFFF_FFFF) r = sx32(ux32);
            else begin r32 = x32 / y32; r = sx32(r32); end
      4'd10: if (uy32 == 32'd0) r = ONES; else begin ur32 = ux32 / uy32; r = sx32(ur32); end
      4'd11: if (uy32 == 32'd0) r = sx32(ux32); else if (ux32 == 32'h8000_0000 && uy32 == 32'hFFFF_FFFF) r = 64'd0;
             else begin r32 = x32 % y32; r = sx32(r32); end
      4'd12: if (uy32 == 32'd0) r = sx32(ux32); else begin ur32 = ux32 % uy32; r = sx32(ur32); end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Number of cycles e_wait stays high for one operation.
  function automatic int ref_lat(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
    bit w, dv, zero, ovf;
    if (o > 4'd12) return 1;
    w    = (o >= 4'd8);
    dv   = (o >= 4'd4 && o <= 4'd7) || (o >= 4'd9);
    zero = w ? (y[31:0] == 32'd0) : (y == 64'd0);
    ovf  = ((o == 4'd4 || o == 4'd6) && x == MINV && y == ONES) ||
           ((o == 4'd9 || o == 4'd11) && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF);
    if (dv && (zero || ovf)) return 1;
    return w ? 33 : 65;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, count stall cycles, then check the DONE window of hold_n cycles.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp_res, input int exp_lat, input int hold_n);
    int cyc;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y; hold = (hold_n > 1);
    #1;
    cyc = 0;
    while (e_wait === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk); #1;
    end
    vectors++;
    chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_ov"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_res"}, result, exp_res);
    for (int k = 2; k <= hold_n; k++) begin
      @(negedge clk); #1;
      chk({tag, "_hold_ov"}, {63'd0, out_valid}, 64'd1);
      chk({tag, "_hold_res"}, result, exp_res);
    end
    hold = 1'b0; in_valid = 1'b0;
    @(negedge clk); #1;
    chk({tag, "_after_ov"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_after_ew"}, {63'd0, e_wait}, 64'd0);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return ONES;
      2: return MINV;
      3: return 64'($urandom_range(0, 7));
      4: return {$urandom, 32'h8000_0000};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [3:0]  ro;
    logic [63:0] rx, ry;
    resetn = 1'b0; in_valid = 1'b0; hold = 1'b0; flush = 1'b0; op = 4'd0; a = 64'd0; b = 64'd0;
    in_valid = 1'b1;
    #12;
    chk("rst_ew", {63'd0, e_wait}, 64'd0);
    chk("rst_ov", {63'd0, out_valid}, 64'd0);
    chk("rst_res", result, 64'd0);
    in_valid = 1'b0;
    @(negedge clk); resetn = 1'b1;

    run_op("mul", 4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 1);
    run_op("mulhu", 4'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1);
    run_op("mulh", 4'd1, ONES, ONES, 64'd0, 65, 1);
    run_op("div", 4'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65, 1);
    run_op("rem", 4'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1);
    run_op("divw", 4'd9, 64'h0000_0000_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 33, 1);
    run_op("divu0", 4'd5, 64'd5, 64'd0, ONES, 1, 1);
    run_op("divovf", 4'd4, MINV, ONES, MINV, 1, 1);
    run_op("removf", 4'd6, MINV, ONES, 64'd0, 1, 1);
    run_op("hold3", 4'd7, 64'd100, 64'd7, 64'd2, 65, 3);

    // Abort mid-CALC with flush, then a clean op.
    @(negedge clk);
    in_valid = 1'b1; op = 4'd4; a = 64'hFFFF_FFFF_FFFF_FFEC; b = 64'd3;
    repeat (11) @(negedge clk);
    #1; flush = 1'b1;
    @(negedge clk); #1;
    chk("flush_ew", {63'd0, e_wait}, 64'd0);
    chk("flush_ov", {63'd0, out_valid}, 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    run_op("postflush", 4'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65, 1);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    in_valid = 1'b1; op = 4'd0; a = 64'd9; b = 64'd9;
    repeat (20) @(negedge clk);
    #1; resetn = 1'b0; #1;
    chk("midrst_ew", {63'd0, e_wait}, 64'd0);
    chk("midrst_ov", {63'd0, out_valid}, 64'd0);
    chk("midrst_res", result, 64'd0);
    in_valid = 1'b0;
    @(negedge clk); resetn = 1'b1;
    run_op("mulw", 4'd8, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1);

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      rx = pick();
      ry = pick();
      run_op("rand", ro, rx, ry, ref_res(ro, rx, ry), ref_lat(ro, rx, ry), int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV64M multiply/divide unit in the execute stage, fed by the E-stage operand registers.
- Raises e_wait toward the hazard unit while an operation is in flight. The hazard unit then stalls F/D/E and bubbles M.
- Returns a registered result on the first cycle e_wait drops. The E stage captures it and advances on that cycle.
- Handles all 64-bit and W-suffix M-extension ops, including RISC-V divide-by-zero and overflow semantics.

Parameters:
- XLEN, 64, datapath width. Only 64 is supported.
- CNT_W, 7, width of the iteration counter. Must hold XLEN.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  E stage holds an M-extension op; operands are stable while e_wait=1
- op  in  4  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW. Codes 13-15 are illegal.
- a  in  64  rs1 value (already forwarded)
- b  in  64  rs2 value (already forwarded)
- hold  in  1  downstream stall (d_wait); E cannot advance this cycle
- flush  in  1  E-stage flush (mret/branch kill); aborts the operation
- e_wait  out  1  busy; E must stall
- out_valid  out  1  result is valid this cycle
- result  out  64  final value; W ops are sign-extended from bit 31

Behaviour:
Reset:
- Clock is clk. Reset is resetn: asynchronous, active-low.
- On reset: state=IDLE, counter=0, all datapath registers 0, result=0, out_valid=0.
- e_wait=0 while resetn=0.
- Reset mid-operation abandons the operation with no output.

FSM states: IDLE, CALC, DONE.

IDLE:
- e_wait = in_valid & ~flush (combinational, so the hazard unit stalls the acceptance cycle).
- On in_valid & ~flush: latch operands and op, then go to CALC.
- Operand latch for W ops: truncate to 32 bits. Signed W ops sign-extend; DIVUW/REMUW zero-extend.
- Operand latch for signed divide: take absolute values and record the result sign.
- Operand latch for MULH/MULHSU: use absolute values as well, with the sign fixed up at the end.
- Short cut, b==0 for a divide: quotient=all ones (W: 0xFFFFFFFF sign-extended), remainder=a (W: sext(a[31:0])). Go straight to DONE and skip CALC.
- Short cut, signed overflow (DIV/REM with a=0x8000000000000000 and b=-1; DIVW/REMW with a[31:0]=0x80000000 and b[31:0]=-1): quotient=a (sign-extended for W), remainder=0. Go to DONE.
- Illegal op: result=0. Go to DONE.

CALC:
- e_wait=1.
- One iteration per cycle.
- Iteration count N is 64 for 64-bit ops and 32 for W ops.
- Multiply: shift-add into a 128-bit accumulator, one multiplier bit per cycle, LSB first.
- Divide: restoring shift-subtract, one quotient bit per cycle, MSB first.
- The counter runs from 0 to N-1. At N-1, apply sign correction and result selection, register the result, and go to DONE.
- Result selection: MUL takes low 64 bits; MULH/MULHSU/MULHU take high 64 bits; W ops take sext of low 32 bits.

DONE:
- e_wait=0, out_valid=1, result held stable.
- If hold=1: stay in DONE with result unchanged.
- Otherwise go to IDLE. No new op is accepted in this cycle, even if in_valid=1, because that is still the same instruction.

Latency:
- Acceptance cycle plus N CALC cycles, then DONE. e_wait is high for N+1 cycles.
- Short cuts: e_wait high for 1 cycle, DONE on the next cycle.

flush:
- In any state, flush=1 forces IDLE on the next edge and drops e_wait/out_valid.
- flush has priority over in_valid and hold.

Simultaneous or edge cases:
- flush & hold: flush wins.
- in_valid dropping during CALC is ignored; only flush aborts an operation.
- out_valid is never asserted in IDLE or CALC.

Test Plan:
- MUL: a=7, b=-3 → e_wait high 65 cycles; DONE: result=0xFFFFFFFFFFFFFFEB, out_valid=1 for 1 cycle.
- MULHU: a=b=0xFFFFFFFFFFFFFFFF → result=0xFFFFFFFFFFFFFFFE. MULH with a=-1, b=-1 → result=0.
- DIV a=-20, b=3 → result=-6. REM with the same operands → result=-2. DIVW a=0x00000000FFFFFFEC, b=3 → result=0xFFFFFFFFFFFFFFFA after 33 e_wait cycles.
- Divide-by-zero DIVU a=5, b=0 → result=0xFFFFFFFFFFFFFFFF, e_wait high exactly 1 cycle. Overflow DIV a=0x8000000000000000, b=-1 → result=0x8000000000000000. REM with the same operands → result=0.
- Stall and abort:
  - hold=1 for 3 cycles while in DONE → result stable and out_valid high all 3 cycles, then IDLE.
  - flush at CALC iteration 10 → next cycle e_wait=0, out_valid=0.
  - A new in_valid after the flush starts cleanly with correct latency.
- Reset: deassert resetn mid-CALC → e_wait, out_valid and result go to 0 immediately (asynchronously). After release, a MULW a=0x7FFFFFFF, b=2 → result=0xFFFFFFFFFFFFFFFE.
